// File: rtl/rename_regfile.sv
// Architectural register file with per-register busy bit and rename tag.
// Registered source lookup, destination allocation, CDB commit write-back and flush.
module rename_regfile #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NREG   = 32,
  parameter int unsigned TAG_W  = 4,
  parameter int unsigned NSRC   = 2,
  localparam int unsigned RIDX_W = $clog2(NREG)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rdy,
  input  logic                   commit_valid,
  input  logic [RIDX_W-1:0]      commit_dest,
  input  logic [XLEN-1:0]        commit_value,
  input  logic [TAG_W-1:0]       commit_tag,
  input  logic                   flush,
  input  logic                   rename_need,
  input  logic [TAG_W-1:0]       rename_need_id,
  input  logic [NSRC-1:0]        src_flag,
  input  logic [NSRC*RIDX_W-1:0] src_reg,
  input  logic [RIDX_W-1:0]      new_rd,
  input  logic [TAG_W-1:0]       new_rd_tag,
  output logic                   rename_finish,
  output logic [TAG_W-1:0]       rename_finish_id,
  output logic [NSRC-1:0]        src_busy,
  output logic [NSRC*TAG_W-1:0]  src_tag,
  output logic [NSRC*XLEN-1:0]   src_data
);

  logic [XLEN-1:0]       r_value [NREG];
  logic [TAG_W-1:0]      r_tag   [NREG];
  logic [NREG-1:0]       r_busy;

  logic                  r_finish;
  logic [TAG_W-1:0]      r_finish_id;
  logic [NSRC-1:0]       r_src_busy;
  logic [NSRC*TAG_W-1:0] r_src_tag;
  logic [NSRC*XLEN-1:0]  r_src_data;

  logic                  w_accept;
  logic                  w_alloc;
  logic                  w_commit_wr;
  logic                  w_commit_clr;
  logic [NSRC-1:0]       w_src_busy;
  logic [NSRC*TAG_W-1:0] w_src_tag;
  logic [NSRC*XLEN-1:0]  w_src_data;

  assign w_accept    = rename_need & rdy & ~flush;
  assign w_alloc     = w_accept & (new_rd != '0);
  assign w_commit_wr = rdy & commit_valid & (commit_dest != '0);
  // Allocation to the committing register in the same cycle keeps it busy.
  assign w_commit_clr = w_commit_wr & (commit_tag == r_tag[commit_dest])
                      & ~(w_alloc & (new_rd == commit_dest));

  // Source resolution against the pre-allocation mapping, with commit bypass.
  always_comb begin
    logic [RIDX_W-1:0] w_idx;
    w_idx      = '0;
    w_src_busy = '0;
    w_src_tag  = '0;
    w_src_data = '0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      w_idx = src_reg[i*RIDX_W +: RIDX_W];
      if (src_flag[i] && (w_idx != '0)) begin
        if (commit_valid && (commit_dest == w_idx) && r_busy[w_idx]
            && (commit_tag == r_tag[w_idx])) begin
          w_src_data[i*XLEN +: XLEN] = commit_value;
        end else if (r_busy[w_idx]) begin
          w_src_busy[i]               = 1'b1;
          w_src_tag[i*TAG_W +: TAG_W] = r_tag[w_idx];
        end else begin
          w_src_data[i*XLEN +: XLEN] = r_value[w_idx];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        r_value[i] <= '0;
        r_tag[i]   <= '0;
      end
      r_busy <= '0;
    end else if (rdy) begin
      if (w_commit_wr) begin
        r_value[commit_dest] <= commit_value;
      end
      if (flush) begin
        r_busy <= '0;
      end else begin
        if (w_commit_clr) begin
          r_busy[commit_dest] <= 1'b0;
        end
        if (w_alloc) begin
          r_busy[new_rd] <= 1'b1;
          r_tag[new_rd]  <= new_rd_tag;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_finish    <= 1'b0;
      r_finish_id <= '0;
      r_src_busy  <= '0;
      r_src_tag   <= '0;
      r_src_data  <= '0;
    end else if (rdy) begin
      r_finish <= w_accept;
      if (w_accept) begin
        r_finish_id <= rename_need_id;
        r_src_busy  <= w_src_busy;
        r_src_tag   <= w_src_tag;
        r_src_data  <= w_src_data;
      end
    end
  end

  assign rename_finish    = r_finish;
  assign rename_finish_id = r_finish_id;
  assign src_busy         = r_src_busy;
  assign src_tag          = r_src_tag;
  assign src_data         = r_src_data;

endmodule

// File: tb/tb_rename_regfile.sv
// Bench for rename_regfile: directed scenarios then random traffic against a rule-level model.
module tb_rename_regfile;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int TAG_W = 4;
  localparam int NSRC = 2;
  localparam int RW = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              rdy;
  logic              commit_valid;
  logic [RW-1:0]     commit_dest;
  logic [XLEN-1:0]   commit_value;
  logic [TAG_W-1:0]  commit_tag;
  logic              flush;
  logic              rename_need;
  logic [TAG_W-1:0]  rename_need_id;
  logic [NSRC-1:0]   src_flag;
  logic [NSRC*RW-1:0] src_reg;
  logic [RW-1:0]     new_rd;
  logic [TAG_W-1:0]  new_rd_tag;
  logic              rename_finish;
  logic [TAG_W-1:0]  rename_finish_id;
  logic [NSRC-1:0]   src_busy;
  logic [NSRC*TAG_W-1:0] src_tag;
  logic [NSRC*XLEN-1:0]  src_data;

  rename_regfile #(.XLEN(XLEN), .NREG(NREG), .TAG_W(TAG_W), .NSRC(NSRC)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .commit_valid(commit_valid), .commit_dest(commit_dest),
    .commit_value(commit_value), .commit_tag(commit_tag),
    .flush(flush), .rename_need(rename_need), .rename_need_id(rename_need_id),
    .src_flag(src_flag), .src_reg(src_reg), .new_rd(new_rd), .new_rd_tag(new_rd_tag),
    .rename_finish(rename_finish), .rename_finish_id(rename_finish_id),
    .src_busy(src_busy), .src_tag(src_tag), .src_data(src_data)
  );

  always #5 clk = ~clk;

  int npass = 0;
  int ntotal = 0;

  // Reference model: architectural state plus the expected registered outputs.
  logic [XLEN-1:0]  m_val  [NREG];
  logic             m_busy [NREG];
  logic [TAG_W-1:0] m_tag  [NREG];
  logic             e_fin;
  logic [TAG_W-1:0] e_id;
  logic             e_busy [NSRC];
  logic [TAG_W-1:0] e_tag  [NSRC];
  logic [XLEN-1:0]  e_data [NSRC];

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) begin
      m_val[i] = '0; m_busy[i] = 1'b0; m_tag[i] = '0;
    end
    e_fin = 1'b0; e_id = '0;
    for (int i = 0; i < NSRC; i++) begin
      e_busy[i] = 1'b0; e_tag[i] = '0; e_data[i] = '0;
    end
  endtask

  task automatic model_step();
    bit accept;
    bit clear_ok;
    int r;
    if (!rdy) return;
    accept = rename_need && !flush;
    e_fin = accept;
    if (accept) begin
      e_id = rename_need_id;
      for (int i = 0; i < NSRC; i++) begin
        r = int'(src_reg[i*RW +: RW]);
        e_busy[i] = 1'b0; e_tag[i] = '0; e_data[i] = '0;
        if (!src_flag[i] || r == 0) begin
          // unused source or x0: zero
        end else if (commit_valid && int'(commit_dest) == r && m_busy[r]
                     && commit_tag == m_tag[r]) begin
          e_data[i] = commit_value;
        end else if (m_busy[r]) begin
          e_busy[i] = 1'b1; e_tag[i] = m_tag[r];
        end else begin
          e_data[i] = m_val[r];
        end
      end
    end
    clear_ok = commit_valid && commit_dest != 0 && commit_tag == m_tag[commit_dest]
               && !(accept && new_rd != 0 && new_rd == commit_dest);
    if (commit_valid && commit_dest != 0) m_val[commit_dest] = commit_value;
    if (flush) begin
      for (int i = 0; i < NREG; i++) m_busy[i] = 1'b0;
    end else begin
      if (clear_ok) m_busy[commit_dest] = 1'b0;
      if (accept && new_rd != 0) begin
        m_busy[new_rd] = 1'b1; m_tag[new_rd] = new_rd_tag;
      end
    end
  endtask

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
  endtask

  task automatic check_all();
    chk("finish", 64'(rename_finish), 64'(e_fin));
    chk("finish_id", 64'(rename_finish_id), 64'(e_id));
    for (int i = 0; i < NSRC; i++) begin
      chk($sformatf("src%0d_busy", i), 64'(src_busy[i]), 64'(e_busy[i]));
      if (e_busy[i]) chk($sformatf("src%0d_tag", i), 64'(src_tag[i*TAG_W +: TAG_W]), 64'(e_tag[i]));
      else           chk($sformatf("src%0d_data", i), 64'(src_data[i*XLEN +: XLEN]), 64'(e_data[i]));
    end
  endtask

  task automatic idle();
    rdy = 1'b1; flush = 1'b0;
    commit_valid = 1'b0; commit_dest = '0; commit_value = '0; commit_tag = '0;
    rename_need = 1'b0; rename_need_id = '0; src_flag = '0; src_reg = '0;
    new_rd = '0; new_rd_tag = '0;
  endtask

  task automatic req(input int id, input int flags, input int s0, input int s1,
                     input int nrd, input int ntag);
    rename_need = 1'b1; rename_need_id = TAG_W'(id); src_flag = NSRC'(flags);
    src_reg = {RW'(s1), RW'(s0)}; new_rd = RW'(nrd); new_rd_tag = TAG_W'(ntag);
  endtask

  task automatic cmt(input int dest, input logic [XLEN-1:0] val, input int tg);
    commit_valid = 1'b1; commit_dest = RW'(dest); commit_value = val; commit_tag = TAG_W'(tg);
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check_all();
    idle();
  endtask

  initial begin
    rst = 1'b0;
    idle();
    model_reset();
    #1;
    check_all();
    #21 rst = 1'b1;

    req(1, 3, 5, 6, 0, 0); step();
    chk("lookup_x5_x6_busy", 64'(src_busy), 64'(0));

    req(2, 0, 0, 0, 3, 7); step();
    req(3, 1, 3, 0, 0, 0); step();
    chk("x3_tag7", 64'(src_tag[0 +: TAG_W]), 64'(7));
    req(4, 1, 3, 0, 0, 0); cmt(3, 32'hDEADBEEF, 7); step();
    chk("x3_bypass", 64'(src_data[0 +: XLEN]), 64'hDEADBEEF);
    req(5, 1, 3, 0, 0, 0); step();

    req(6, 0, 0, 0, 4, 2); step();
    req(7, 0, 0, 0, 4, 5); step();
    req(8, 3, 4, 4, 0, 0); cmt(4, 32'h11, 2); step();
    chk("x4_still_tag5", 64'(src_tag[TAG_W +: TAG_W]), 64'(5));
    cmt(4, 32'h55, 5); step();
    req(9, 1, 4, 0, 0, 0); step();

    cmt(9, 32'h42, 0); step();
    req(10, 1, 9, 0, 9, 3); step();
    chk("x9_old_value", 64'(src_data[0 +: XLEN]), 64'h42);
    req(11, 2, 0, 9, 0, 0); step();

    req(12, 0, 0, 0, 0, 6); cmt(0, 32'h77, 6); step();
    req(13, 3, 0, 0, 0, 0); step();
    req(14, 0, 9, 9, 0, 0); step();

    req(15, 3, 9, 8, 8, 1); cmt(8, 32'h99, 0); flush = 1'b1; step();
    req(1, 3, 9, 8, 0, 0); step();
    chk("x8_after_flush", 64'(src_data[XLEN +: XLEN]), 64'h99);

    req(2, 3, 8, 9, 8, 4); step();
    req(3, 3, 8, 9, 9, 5); cmt(8, 32'hAA, 4); rdy = 1'b0; step();
    req(4, 3, 8, 9, 0, 0); step();

    req(5, 0, 0, 0, 10, 1); step();
    req(6, 0, 0, 0, 10, 6); cmt(10, 32'hAB, 1); step();
    req(7, 1, 10, 0, 0, 0); step();

    req(8, 3, 10, 4, 11, 2);
    #3 rst = 1'b0;
    model_reset();
    @(posedge clk); #1;
    check_all();
    #2 rst = 1'b1;
    idle();

    for (int n = 0; n < 400; n++) begin
      int cd;
      rdy   = ($urandom_range(0, 9) != 0);
      flush = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 3) != 0)
        req(int'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
            int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
            int'($urandom_range(0, 7)), int'($urandom_range(0, 15)));
      if ($urandom_range(0, 1) != 0) begin
        cd = int'($urandom_range(0, 7));
        cmt(cd, $urandom, ($urandom_range(0, 2) != 0) ? int'(m_tag[cd])
                                                      : int'($urandom_range(0, 15)));
      end
      step();
    end

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
